// File: rtl/spi_inemo4.sv
// SPI-mode-0 slave model of an inertial sensor yaw channel: a small register
// map, periodic yaw snapshots at the output data rate, and a data-ready INT.
module spi_inemo4 #(
   parameter int          ODR_CYCLES   = 2048,
   parameter logic [7:0]  WHO_AM_I_VAL = 8'h6A
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        SS_n,
   input  logic        SCLK,
   input  logic        MOSI,
   output logic        MISO,
   output logic        INT,
   input  logic [15:0] YAW
);

   localparam int CNT_W = (ODR_CYCLES > 1) ? $clog2(ODR_CYCLES) : 1;

   typedef enum logic {ST_IDLE, ST_FRAME} state_t;

   state_t       state;
   state_t       state_next;
   logic         frame_start;
   logic         frame_end;

   logic [2:0]   ss_pipe;
   logic [2:0]   sclk_pipe;
   logic [1:0]   mosi_pipe;
   logic         ss_s;
   logic         ss_fall;
   logic         ss_rise;
   logic         sclk_rise;
   logic         sclk_fall;
   logic         mosi_s;

   logic [4:0]   bit_cnt;
   logic [15:0]  shift_in;
   logic [7:0]   miso_sr;
   logic         miso_bit;
   logic         rd_frame;
   logic [6:0]   cmd_addr;
   logic [7:0]   rd_byte;

   logic [7:0]   int1_ctrl;
   logic [7:0]   ctrl2_g;
   logic [15:0]  yaw_hold;
   logic [CNT_W-1:0] odr_cnt;
   logic         sample_pend;
   logic         int_r;
   logic         int_en;
   logic         odr_wrap;
   logic         sample_now;
   logic         wr_ok;
   logic         rd_clear;

   // Synchronizers reset to 0 so an SS_n held low across reset never looks
   // like a fresh falling edge; the slave waits for a real high-to-low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ss_pipe   <= '0;
         sclk_pipe <= '0;
         mosi_pipe <= '0;
      end else begin
         ss_pipe   <= {ss_pipe[1:0], SS_n};
         sclk_pipe <= {sclk_pipe[1:0], SCLK};
         mosi_pipe <= {mosi_pipe[0], MOSI};
      end
   end

   assign ss_s      = ss_pipe[1];
   assign ss_fall   = ss_pipe[2] & ~ss_pipe[1];
   assign ss_rise   = ~ss_pipe[2] & ss_pipe[1];
   assign sclk_rise = ~sclk_pipe[2] & sclk_pipe[1];
   assign sclk_fall = sclk_pipe[2] & ~sclk_pipe[1];
   assign mosi_s    = mosi_pipe[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next  = state;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (ss_fall) begin
               state_next  = ST_FRAME;
               frame_start = 1'b1;
            end
         end
         ST_FRAME: begin
            if (ss_rise) begin
               state_next = ST_IDLE;
               frame_end  = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign cmd_addr = {shift_in[5:0], mosi_s};

   always_comb begin
      rd_byte = 8'h00;
      case (cmd_addr)
         7'h0F:   rd_byte = WHO_AM_I_VAL;
         7'h0D:   rd_byte = int1_ctrl;
         7'h11:   rd_byte = ctrl2_g;
         7'h26:   rd_byte = yaw_hold[7:0];
         7'h27:   rd_byte = yaw_hold[15:8];
         default: rd_byte = 8'h00;
      endcase
   end

   // The bit counter saturates so over-long frames can never alias to 16.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt  <= '0;
         shift_in <= '0;
         miso_sr  <= '0;
         miso_bit <= 1'b0;
         rd_frame <= 1'b0;
      end else if (frame_start) begin
         bit_cnt  <= '0;
         miso_sr  <= '0;
         miso_bit <= 1'b0;
         rd_frame <= 1'b0;
      end else if (state == ST_FRAME) begin
         if (sclk_rise) begin
            shift_in <= {shift_in[14:0], mosi_s};
            if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
               rd_frame <= shift_in[6];
               if (shift_in[6]) miso_sr <= rd_byte;
            end
         end else if (sclk_fall && rd_frame && (bit_cnt >= 5'd8)) begin
            miso_bit <= miso_sr[7];
            miso_sr  <= {miso_sr[6:0], 1'b0};
         end
      end
   end

   assign wr_ok    = frame_end && (bit_cnt == 5'd16) && !shift_in[15];
   assign rd_clear = frame_end && (bit_cnt == 5'd16) && shift_in[15] &&
                     (shift_in[14:8] == 7'h27);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         int1_ctrl <= 8'h00;
         ctrl2_g   <= 8'h00;
      end else if (wr_ok) begin
         if (shift_in[14:8] == 7'h0D) int1_ctrl <= shift_in[7:0];
         if (shift_in[14:8] == 7'h11) ctrl2_g   <= shift_in[7:0];
      end
   end

   assign int_en     = int1_ctrl[1];
   assign odr_wrap   = int_en && (odr_cnt == CNT_W'(ODR_CYCLES - 1));
   assign sample_now = (odr_wrap || sample_pend) && ss_s;

   // A wrap while the controller holds SS_n low is parked in sample_pend so
   // both bytes of one sample can be read across two frames coherently.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         odr_cnt     <= '0;
         sample_pend <= 1'b0;
         yaw_hold    <= 16'h0000;
         int_r       <= 1'b0;
      end else if (!int_en) begin
         odr_cnt     <= '0;
         sample_pend <= 1'b0;
         int_r       <= 1'b0;
      end else begin
         odr_cnt <= odr_wrap ? '0 : odr_cnt + 1'b1;
         if (sample_now) begin
            yaw_hold    <= YAW;
            int_r       <= 1'b1;
            sample_pend <= 1'b0;
         end else begin
            if (odr_wrap) sample_pend <= 1'b1;
            if (rd_clear) int_r <= 1'b0;
         end
      end
   end

   assign INT  = int_r;
   assign MISO = ((state == ST_FRAME) && !SS_n) ? miso_bit : 1'bz;

endmodule

// File: tb/tb_spi_inemo4.sv
// Directed self-checking bench for spi_inemo4: register access, sampling,
// INT handling, deferred snapshots and mid-frame reset.
module tb_spi_inemo4;

   localparam int ODR  = 2048;
   localparam int HALF = 10;

   logic        clk;
   logic        rst_n;
   logic        SS_n;
   logic        SCLK;
   logic        MOSI;
   logic        INT;
   logic [15:0] YAW;
   wire         miso_w;

   int          n_cmp;
   int          n_err;
   int          cyc;

   pullup (miso_w);

   spi_inemo4 #(.ODR_CYCLES(ODR), .WHO_AM_I_VAL(8'h6A)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .SS_n  (SS_n),
      .SCLK  (SCLK),
      .MOSI  (MOSI),
      .MISO  (miso_w),
      .INT   (INT),
      .YAW   (YAW)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_range(input string tag, input int obs, input int lo, input int hi);
      n_cmp++;
      assert (obs >= lo && obs <= hi) else begin
         n_err++;
         $error("[TB] FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns with SS_n just raised; the caller decides the idle gap.
   task automatic spi_frame(input logic [15:0] tx, input int nbits,
                            output logic [7:0] cmd_rx, output logic [7:0] data_rx);
      cmd_rx  = 8'h00;
      data_rx = 8'h00;
      SS_n = 1'b0;
      idle(10);
      for (int i = 0; i < nbits; i++) begin
         MOSI = tx[15 - i];
         idle(HALF);
         SCLK = 1'b1;
         if (i < 8) cmd_rx  = {cmd_rx[6:0], miso_w};
         else       data_rx = {data_rx[6:0], miso_w};
         idle(HALF);
         SCLK = 1'b0;
      end
      idle(HALF);
      SS_n = 1'b1;
   endtask

   task automatic read_reg(input logic [15:0] tx, output logic [7:0] data_rx);
      logic [7:0] c;
      spi_frame(tx, 16, c, data_rx);
      idle(10);
   endtask

   task automatic write_reg(input logic [15:0] tx);
      logic [7:0] c;
      logic [7:0] d;
      spi_frame(tx, 16, c, d);
      idle(10);
   endtask

   task automatic wait_int(input logic level, input int limit, output int n);
      n = 0;
      while (INT !== level && n <= limit) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic int_quiet(input int n, output logic seen);
      seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (INT !== 1'b0) seen = 1'b1;
      end
   endtask

   initial begin
      logic [7:0] c;
      logic [7:0] d;
      logic       seen;
      int         n;
      int         c0;

      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      SS_n  = 1'b1;
      SCLK  = 1'b0;
      MOSI  = 1'b0;
      YAW   = 16'h0000;
      idle(5);
      rst_n = 1'b1;
      idle(5);

      check("int_reset", {15'd0, INT}, 16'h0000);
      check("miso_idle", {15'd0, miso_w}, 16'h0001);

      spi_frame(16'h8F00, 16, c, d);
      idle(10);
      check("whoami_cmd_miso", {8'h00, c}, 16'h0000);
      check("whoami_data", {8'h00, d}, 16'h006A);
      check("int_after_whoami", {15'd0, INT}, 16'h0000);

      int_quiet(3 * ODR, seen);
      check("int_disabled_quiet", {15'd0, seen}, 16'h0000);
      read_reg(16'hA600, d);
      check("outz_l_reset", {8'h00, d}, 16'h0000);
      read_reg(16'h8D00, d);
      check("int1_ctrl_reset", {8'h00, d}, 16'h0000);

      write_reg(16'h1150);
      read_reg(16'h9100, d);
      check("ctrl2_g_rw", {8'h00, d}, 16'h0050);

      spi_frame(16'h0D02, 12, c, d);
      idle(10);
      read_reg(16'h8D00, d);
      check("abort_no_write", {8'h00, d}, 16'h0000);
      int_quiet(ODR + 200, seen);
      check("abort_no_int", {15'd0, seen}, 16'h0000);

      YAW = 16'h1234;
      spi_frame(16'h0D02, 16, c, d);
      wait_int(1'b1, 2 * ODR, n);
      check_range("int_latency", n, ODR - 4, ODR + 4);
      idle(10);
      read_reg(16'hA600, d);
      check("outz_l_1234", {8'h00, d}, 16'h0034);
      check("int_held_after_a6", {15'd0, INT}, 16'h0001);
      spi_frame(16'hA700, 16, c, d);
      check("outz_h_1234", {8'h00, d}, 16'h0012);
      wait_int(1'b0, 10, n);
      check_range("int_clear_latency", n, 0, 4);
      idle(10);

      wait_int(1'b1, 2 * ODR, n);
      check_range("int_rearm", n, 0, 2 * ODR);
      write_reg(16'h0D00);
      check("int_off_on_disable", {15'd0, INT}, 16'h0000);
      read_reg(16'h8D00, d);
      check("int1_ctrl_cleared", {8'h00, d}, 16'h0000);

      YAW = 16'h00FF;
      write_reg(16'h0D02);
      wait_int(1'b1, 2 * ODR, n);
      check_range("int_boundary_setup", n, 0, 2 * ODR);
      c0 = cyc;
      read_reg(16'hA700, d);
      check("outz_h_00ff", {8'h00, d}, 16'h0000);
      while (cyc < c0 + 1950) @(negedge clk);
      YAW = 16'h0100;
      spi_frame(16'hA600, 16, c, d);
      check("boundary_old_low", {8'h00, d}, 16'h00FF);
      check("int_deferred_low", {15'd0, INT}, 16'h0000);
      wait_int(1'b1, 8, n);
      check_range("int_deferred_set", n, 0, 8);
      idle(10);
      read_reg(16'hA600, d);
      check("outz_l_new", {8'h00, d}, 16'h0000);
      read_reg(16'hA700, d);
      check("outz_h_new", {8'h00, d}, 16'h0001);

      wait_int(1'b1, 2 * ODR, n);
      check("int_before_reset", {15'd0, INT}, 16'h0001);
      SS_n = 1'b0;
      idle(10);
      for (int i = 0; i < 4; i++) begin
         MOSI = 1'b1;
         idle(HALF);
         SCLK = 1'b1;
         idle(HALF);
         SCLK = 1'b0;
      end
      check("miso_cmd_driven", {15'd0, miso_w}, 16'h0000);
      rst_n = 1'b0;
      idle(2);
      check("int_mid_reset", {15'd0, INT}, 16'h0000);
      check("miso_mid_reset", {15'd0, miso_w}, 16'h0001);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         idle(HALF);
         SCLK = 1'b1;
         idle(HALF);
         SCLK = 1'b0;
      end
      check("miso_stray_after_reset", {15'd0, miso_w}, 16'h0001);
      idle(HALF);
      SS_n = 1'b1;
      idle(20);
      read_reg(16'h8F00, d);
      check("whoami_after_reset", {8'h00, d}, 16'h006A);
      read_reg(16'h8D00, d);
      check("int1_ctrl_after_reset", {8'h00, d}, 16'h0000);
      check("int_after_reset", {15'd0, INT}, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/spi_inemo4.md
Name: spi_inemo4

Overview:
- Behavioural/synthesizable model of an SPI inertial sensor (gyro yaw channel) used in the Knight simulation environment.
- SPI slave, mode 0, 16-bit frames: the controller configures the part, reads WHO_AM_I and reads the 16-bit yaw rate supplied on the YAW input.
- Signals new-data availability on INT.

Parameters:
- ODR_CYCLES, 2048, clk cycles between yaw samples (output data rate).
- WHO_AM_I_VAL, 8'h6A, value returned from address 0x0F.

Ports:
- clk   input  1   system clock; SCLK half-period ≥ 8 clk
- rst_n input  1   reset (asynchronous, active-low)
- SS_n  input  1   active-low slave select, asynchronous to clk
- SCLK  input  1   serial clock, idle low, asynchronous to clk
- MOSI  input  1   serial data from controller
- MISO  output 1   serial data to controller
- INT   output 1   data-ready interrupt, active high
- YAW   input  16  signed yaw rate to report

Behaviour:
Input conditioning:
- Reset: rst_n asynchronous, active-low; clock clk.
- SS_n, SCLK and MOSI pass through 2-flop synchronizers; edges are detected on the synchronized copies.
- Effective latency is 3 clk from a pin edge to its action.

Framing:
- A frame starts on the SS_n fall and ends on the SS_n rise.
- MOSI is sampled on the SCLK rise; MISO changes on the SCLK fall; MSB first.
- Bit 15: R/W (1 = read). Bits 14:8: address. Bits 7:0: write data, or don't-care on a read.
- Bit counter clears on the SS_n fall.

Read:
- After the 8th sampled bit, if R/W = 1, the addressed byte loads into the MISO shift register.
- The 8 data bits are presented MSB first: bit 7 is valid after the 8th SCLK fall, then shifts on each following fall.
- During the command byte MISO = 0.

Write:
- Committed on the SS_n rise, only if exactly 16 bits were sampled and R/W = 0.
- Frames with any other bit count are discarded with no side effects: no write, no INT clear.

MISO when idle:
- MISO = 1'bz while SS_n is high.

Register map:
- 0x0F WHO_AM_I: read-only, WHO_AM_I_VAL.
- 0x0D INT1_CTRL: R/W, reset 0x00; bit 1 = data-ready INT enable.
- 0x11 CTRL2_G: R/W, reset 0x00; stored only, no other effect.
- 0x26 OUTZ_L_G: read-only, yaw_hold[7:0].
- 0x27 OUTZ_H_G: read-only, yaw_hold[15:8].
- All other addresses read 0x00; writes to them are ignored.

Sampling:
- Free-running counter 0..ODR_CYCLES-1 runs while INT1_CTRL[1] = 1.
- The counter clears and holds while INT1_CTRL[1] = 0.
- On wrap, yaw_hold ← YAW as a coherent 16-bit snapshot and INT ← 1.
- yaw_hold updates only when SS_n is high (synchronized). A wrap during a frame is deferred to the first clk after SS_n rises.
- Low and high bytes of one sample are therefore consistent across two frames.

INT:
- Cleared at the end of a complete read frame to 0x27.
- If a new sample and a clear coincide, the set wins.
- A new sample while INT = 1 overwrites yaw_hold; INT stays 1.
- Disabling INT1_CTRL[1] clears INT.

Reset values:
- INT = 0, MISO = z, INT1_CTRL = CTRL2_G = 0, yaw_hold = 0, counters = 0.
- Reset mid-frame aborts the frame; the slave waits for a fresh SS_n fall.

Test Plan:
- Read frame 16'h8F00 → MISO data byte 8'h6A. INT stays 0. No register changes.
- Write 16'h0D02, YAW = 16'h1234 held → INT rises ODR_CYCLES (±4) clk later. Reads of 16'hA600/16'hA700 return 8'h34/8'h12. INT falls ≤4 clk after the SS_n rise of the 0xA7 frame.
- INT1_CTRL = 0 (after reset) → INT stays 0 for 3×ODR_CYCLES; read of 0xA6 returns 8'h00.
- Write 0x0D02 then 0x0D00 while INT = 1 → INT clears. Read of 0x8D00 returns 8'h00. Read of 0x9100 after writing 0x1150 returns 8'h50.
- Frame 0x0D02 aborted after 12 bits (SS_n raised) → no INT ever.
- Sample boundary and reset:
  - Sample boundary falls inside a 0xA6 read frame with YAW changing 16'h00FF→16'h0100 → the frame returns the old low byte. The new value is latched after SS_n rises. The following 0xA6/0xA7 pair returns 8'h00/8'h01.
  - rst_n pulsed low mid-frame → INT = 0, MISO = z. The next full WHO_AM_I read returns 8'h6A.
